// File: rtl/vga_draw_pkg.sv
// Shared types for the VGA draw scheduler: screen size, image codes,
// FSM encoding and the queued draw-command record.
package vga_draw_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef enum logic [3:0] {
    IMG_START      = 4'd0,
    IMG_CARD1      = 4'd1,
    IMG_CARD2      = 4'd2,
    IMG_CARD3      = 4'd3,
    IMG_CARD4      = 4'd4,
    IMG_CARD5      = 4'd5,
    IMG_CARD6      = 4'd6,
    IMG_CARD7      = 4'd7,
    IMG_BACKGROUND = 4'd8,
    IMG_GAMEOVER   = 4'd9
  } img_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAW  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // 34-bit rectangle blit request
  typedef struct packed {
    logic [3:0] img;
    logic [7:0] x;
    logic [6:0] y;
    logic [7:0] w;
    logic [6:0] h;
  } draw_cmd_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] img;
    logic [7:0] x;
    logic [6:0] y;
  } plot_t;

endpackage

// File: rtl/vga_draw_scheduler_fifo.sv
// Synchronous command queue for the draw scheduler; flush empties it
// in one clock without touching the storage array.
module draw_cmd_fifo
  import vga_draw_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  draw_cmd_t                din,
  output draw_cmd_t                dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  draw_cmd_t     r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign full      = (r_count == FULL_CNT);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  // a pop frees the slot the simultaneous push lands in
  assign w_do_push = push && (!full || pop);
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clock) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/vga_draw_scheduler.sv
// Walks queued rectangle blits one pixel per clock, driving the image-ROM
// address and a plot port delayed to line up with ROM read data.
//   state | meaning
//   IDLE  | waiting; pops the next command when the queue is non-empty
//   LOAD  | clears col/row/addr, skips straight to DRAIN on a zero-size blit
//   DRAW  | issues one ROM address per clock, row-major
//   DRAIN | lets the last ROM read land, then pulses blit_done
module vga_draw_scheduler #(
  parameter int FIFO_DEPTH  = 4,
  parameter int ROM_LATENCY = 1,
  parameter int SCREEN_W    = vga_draw_pkg::SCREEN_W,
  parameter int SCREEN_H    = vga_draw_pkg::SCREEN_H
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        flush,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_img,
  input  logic [7:0]  cmd_x,
  input  logic [6:0]  cmd_y,
  input  logic [7:0]  cmd_w,
  input  logic [6:0]  cmd_h,
  output logic [14:0] rom_address,
  output logic [3:0]  img_select,
  output logic [7:0]  x_plot,
  output logic [6:0]  y_plot,
  output logic        vga_enable,
  output logic        busy,
  output logic        blit_done
);

  import vga_draw_pkg::*;

  localparam int          CW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [8:0]  X_LIM      = 9'(SCREEN_W);
  localparam logic [7:0]  Y_LIM      = 8'(SCREEN_H);
  localparam logic [1:0]  DRAIN_LOAD = 2'(ROM_LATENCY - 1);

  draw_cmd_t       w_cmd_in;
  draw_cmd_t       w_cmd_out;
  logic            w_full;
  logic            w_empty;
  logic [CW-1:0]   w_count;
  logic            w_push;
  logic            w_pop;

  state_e          r_state;
  draw_cmd_t       r_cmd;
  logic [7:0]      r_col;
  logic [6:0]      r_row;
  logic [14:0]     r_addr;
  logic [1:0]      r_timer;
  logic            r_done;
  plot_t           r_pipe [ROM_LATENCY];

  logic [8:0]      w_x_sum;
  logic [7:0]      w_y_sum;
  logic            w_in_bounds;
  logic            w_last_col;
  logic            w_last_row;
  logic            w_pipe_busy;

  assign cmd_ready = !w_full && !flush;
  assign w_push    = cmd_valid && cmd_ready;
  assign w_pop     = (r_state == IDLE) && !w_empty && !flush;
  assign w_cmd_in  = {cmd_img, cmd_x, cmd_y, cmd_w, cmd_h};

  draw_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock  (clock),
    .resetn (resetn),
    .flush  (flush),
    .push   (w_push),
    .pop    (w_pop),
    .din    (w_cmd_in),
    .dout   (w_cmd_out),
    .full   (w_full),
    .empty  (w_empty),
    .count  (w_count)
  );

  // widened sums so an origin near the edge cannot wrap back on screen
  assign w_x_sum     = {1'b0, r_cmd.x} + {1'b0, r_col};
  assign w_y_sum     = {1'b0, r_cmd.y} + {1'b0, r_row};
  assign w_in_bounds = (w_x_sum < X_LIM) && (w_y_sum < Y_LIM);
  assign w_last_col  = (r_col == r_cmd.w - 8'd1);
  assign w_last_row  = (r_row == r_cmd.h - 7'd1);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_cmd   <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_addr  <= '0;
      r_timer <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (flush) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (!w_empty) begin
              r_cmd   <= w_cmd_out;
              r_state <= LOAD;
            end
          end
          LOAD: begin
            r_col   <= '0;
            r_row   <= '0;
            r_addr  <= '0;
            r_timer <= DRAIN_LOAD;
            if (r_cmd.w == 8'd0 || r_cmd.h == 7'd0) r_state <= DRAIN;
            else                                    r_state <= DRAW;
          end
          DRAW: begin
            if (w_last_col) begin
              r_col <= '0;
              if (w_last_row) r_state <= DRAIN;
              else            r_row   <= r_row + 7'd1;
            end else begin
              r_col <= r_col + 8'd1;
            end
            // hold the final address rather than stepping past the image
            if (!(w_last_col && w_last_row)) r_addr <= r_addr + 15'd1;
          end
          DRAIN: begin
            if (r_timer == 2'd0) begin
              r_done  <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_timer <= r_timer - 2'd1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < ROM_LATENCY; i++) r_pipe[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < ROM_LATENCY; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= '{valid: (r_state == DRAW) && w_in_bounds,
                     img:   r_cmd.img,
                     x:     w_x_sum[7:0],
                     y:     w_y_sum[6:0]};
      for (int i = 1; i < ROM_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  always_comb begin
    w_pipe_busy = 1'b0;
    for (int i = 0; i < ROM_LATENCY; i++) w_pipe_busy = w_pipe_busy | r_pipe[i].valid;
  end

  assign rom_address = r_addr;
  assign blit_done   = r_done;
  assign vga_enable  = r_pipe[ROM_LATENCY-1].valid;
  assign img_select  = r_pipe[ROM_LATENCY-1].img;
  assign x_plot      = r_pipe[ROM_LATENCY-1].x;
  assign y_plot      = r_pipe[ROM_LATENCY-1].y;
  assign busy        = (r_state != IDLE) || (w_count != '0) || w_pipe_busy;

endmodule

// File: tb/tb_vga_draw_scheduler.sv
// Directed bench for vga_draw_scheduler: full-screen, clipped card,
// queue back-pressure, zero-size blit, flush and async reset.
module tb_vga_draw_scheduler;

  localparam int L = 1;

  logic        clock = 1'b0;
  logic        resetn;
  logic        flush;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_img;
  logic [7:0]  cmd_x;
  logic [6:0]  cmd_y;
  logic [7:0]  cmd_w;
  logic [6:0]  cmd_h;
  logic [14:0] rom_address;
  logic [3:0]  img_select;
  logic [7:0]  x_plot;
  logic [6:0]  y_plot;
  logic        vga_enable;
  logic        busy;
  logic        blit_done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic       mon_clr = 1'b0;
  logic       chk_pix = 1'b0;
  int         exp_x0, exp_y0, exp_w;
  logic [3:0] exp_img;
  int         push_cyc;

  int en_cnt, done_cnt, pix_err, a159;
  int first_x, first_y, first_addr, first_en_cyc;
  int last_x, last_y, last_addr, last_en_cyc, done_cyc;
  logic [3:0]  img_log [$];
  logic [14:0] hist [4];

  always #5 clock = ~clock;

  vga_draw_scheduler #(
    .FIFO_DEPTH  (4),
    .ROM_LATENCY (L),
    .SCREEN_W    (160),
    .SCREEN_H    (120)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .flush       (flush),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_img     (cmd_img),
    .cmd_x       (cmd_x),
    .cmd_y       (cmd_y),
    .cmd_w       (cmd_w),
    .cmd_h       (cmd_h),
    .rom_address (rom_address),
    .img_select  (img_select),
    .x_plot      (x_plot),
    .y_plot      (y_plot),
    .vga_enable  (vga_enable),
    .busy        (busy),
    .blit_done   (blit_done)
  );

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Monitor: plotted pixel at cycle k pairs with the address issued L cycles earlier
  initial begin
    for (int i = 0; i < 4; i++) hist[i] = '0;
    forever begin
      @(negedge clock);
      if (mon_clr) begin
        en_cnt = 0; done_cnt = 0; pix_err = 0; a159 = -1;
        first_x = -1; first_y = -1; first_addr = -1; first_en_cyc = -1;
        last_x = -1; last_y = -1; last_addr = -1; last_en_cyc = -1; done_cyc = -1;
        img_log.delete();
      end else begin
        if (vga_enable === 1'b1) begin
          if (en_cnt == 0) begin
            first_x = int'(x_plot); first_y = int'(y_plot);
            first_addr = int'(hist[L-1]); first_en_cyc = cyc;
          end
          last_x = int'(x_plot); last_y = int'(y_plot);
          last_addr = int'(hist[L-1]); last_en_cyc = cyc;
          if (x_plot == 8'd159 && y_plot == 7'd40) a159 = int'(hist[L-1]);
          if (img_log.size() == 0 || img_log[$] != img_select) img_log.push_back(img_select);
          if (chk_pix && ((int'(hist[L-1]) != (int'(y_plot) - exp_y0) * exp_w + (int'(x_plot) - exp_x0))
                          || img_select != exp_img || x_plot >= 8'd160 || y_plot >= 7'd120))
            pix_err++;
          en_cnt++;
        end
        if (blit_done === 1'b1) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
      for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = rom_address;
    end
  end

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clock);
    #1 mon_clr = 1'b0;
  endtask

  task automatic junk_fields();
    cmd_img = 4'hF; cmd_x = 8'hAA; cmd_y = 7'h55; cmd_w = 8'hFF; cmd_h = 7'h7F;
  endtask

  task automatic push(input logic [3:0] img, input logic [7:0] x, input logic [6:0] y,
                      input logic [7:0] w, input logic [6:0] h);
    @(negedge clock);
    cmd_img = img; cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h;
    cmd_valid = 1'b1;
    @(posedge clock);
    #1 push_cyc = cyc;
    cmd_valid = 1'b0;
    junk_fields();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      #1 n++;
    end while (busy && n < budget);
    check(tag, int'(busy), 0);
  endtask

  function automatic int log_seq();
    int s;
    s = 0;
    for (int i = 0; i < img_log.size() && i < 6; i++) s = (s << 4) | int'(img_log[i]);
    return s;
  endfunction

  initial begin
    int n;
    int en_at;
    resetn = 1'b0; flush = 1'b0; cmd_valid = 1'b0;
    cmd_img = '0; cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0;
    repeat (3) @(negedge clock);
    #1;
    check("rst_addr", int'(rom_address), 0);
    check("rst_en", int'(vga_enable), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(blit_done), 0);
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_xy_img", int'({x_plot, y_plot, img_select}), 0);
    @(negedge clock);
    resetn = 1'b1;

    // 1: full-screen background
    clear_mon();
    exp_x0 = 0; exp_y0 = 0; exp_w = 160; exp_img = 4'd8; chk_pix = 1'b1;
    push(4'd8, 8'd0, 7'd0, 8'd160, 7'd120);
    wait_idle("t1_idle", 20000);
    check("t1_en_cnt", en_cnt, 19200);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_first_xy", first_x * 1000 + first_y, 0);
    check("t1_first_addr", first_addr, 0);
    check("t1_last_x", last_x, 159);
    check("t1_last_y", last_y, 119);
    check("t1_last_addr", last_addr, 19199);
    check("t1_first_lat", first_en_cyc - push_cyc, 3);
    check("t1_done_lat", done_cyc - last_en_cyc, 1);
    check("t1_pix", pix_err, 0);

    // 2: card clipped at the right edge
    clear_mon();
    exp_x0 = 150; exp_y0 = 40; exp_w = 20; exp_img = 4'd3; chk_pix = 1'b1;
    push(4'd3, 8'd150, 7'd40, 8'd20, 7'd40);
    wait_idle("t2_idle", 2000);
    check("t2_en_cnt", en_cnt, 400);
    check("t2_pix", pix_err, 0);
    check("t2_done_cnt", done_cnt, 1);
    check("t2_addr_159_40", a159, 9);
    check("t2_first_x", first_x, 150);
    check("t2_last_addr", last_addr, 789);
    check("t2_img_log", log_seq(), 3);

    // 3: queue back-pressure and ordering
    clear_mon();
    chk_pix = 1'b0;
    push(4'd8, 8'd0, 7'd0, 8'd160, 7'd120);
    repeat (10) @(negedge clock);
    push(4'd1, 8'd10, 7'd10, 8'd2, 7'd2);
    push(4'd2, 8'd20, 7'd10, 8'd2, 7'd2);
    push(4'd3, 8'd30, 7'd10, 8'd2, 7'd2);
    push(4'd4, 8'd40, 7'd10, 8'd2, 7'd2);
    @(negedge clock);
    #1 check("t3_full_ready", int'(cmd_ready), 0);
    cmd_img = 4'd5; cmd_x = 8'd50; cmd_y = 7'd10; cmd_w = 8'd2; cmd_h = 7'd2;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 25000) begin
      @(negedge clock);
      #1 n++;
    end
    check("t3_held_ready", int'(cmd_ready), 1);
    check("t3_held_done", done_cnt, 1);
    check("t3_held_long", int'(n > 1000), 1);
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    junk_fields();
    wait_idle("t3_idle", 2000);
    check("t3_done_cnt", done_cnt, 6);
    check("t3_en_cnt", en_cnt, 19220);
    check("t3_log_size", img_log.size(), 6);
    check("t3_order", log_seq(), 32'h812345);

    // 4: zero-width blit followed by a normal one
    clear_mon();
    exp_x0 = 20; exp_y0 = 30; exp_w = 3; exp_img = 4'd7; chk_pix = 1'b1;
    push(4'd6, 8'd0, 7'd0, 8'd0, 7'd5);
    push(4'd7, 8'd20, 7'd30, 8'd3, 7'd2);
    wait_idle("t4_idle", 200);
    check("t4_done_cnt", done_cnt, 2);
    check("t4_en_cnt", en_cnt, 6);
    check("t4_img_log", log_seq(), 7);
    check("t4_pix", pix_err, 0);

    // 5: flush mid-blit with two commands queued
    clear_mon();
    chk_pix = 1'b0;
    push(4'd8, 8'd0, 7'd0, 8'd160, 7'd120);
    push(4'd1, 8'd10, 7'd10, 8'd2, 7'd2);
    push(4'd2, 8'd20, 7'd10, 8'd2, 7'd2);
    n = 0;
    while (en_cnt < 500 && n < 2000) begin
      @(negedge clock);
      #1 n++;
    end
    check("t5_reach500", en_cnt, 500);
    flush = 1'b1;
    cmd_img = 4'd6; cmd_x = 8'd0; cmd_y = 7'd0; cmd_w = 8'd2; cmd_h = 7'd2;
    cmd_valid = 1'b1;
    #1 check("t5_flush_ready", int'(cmd_ready), 0);
    @(posedge clock);
    #1 flush = 1'b0;
    cmd_valid = 1'b0;
    en_at = en_cnt;
    @(negedge clock);
    #1 check("t5_en_next", int'(vga_enable), 0);
    repeat (40) @(negedge clock);
    #1;
    check("t5_no_more_en", en_cnt, en_at);
    check("t5_no_done", done_cnt, 0);
    check("t5_busy", int'(busy), 0);
    check("t5_ready", int'(cmd_ready), 1);

    // 6: asynchronous reset mid-blit
    clear_mon();
    push(4'd8, 8'd0, 7'd0, 8'd160, 7'd120);
    repeat (100) @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    check("t6_rst_en", int'(vga_enable), 0);
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_addr", int'(rom_address), 0);
    check("t6_rst_xy", int'({x_plot, y_plot}), 0);
    check("t6_rst_ready", int'(cmd_ready), 1);
    @(negedge clock);
    check("t6_no_done", done_cnt, 0);
    #1 resetn = 1'b1;
    clear_mon();
    exp_x0 = 0; exp_y0 = 0; exp_w = 4; exp_img = 4'd9; chk_pix = 1'b1;
    push(4'd9, 8'd0, 7'd0, 8'd4, 7'd3);
    wait_idle("t6_idle", 200);
    check("t6_first_addr", first_addr, 0);
    check("t6_en_cnt", en_cnt, 12);
    check("t6_done_cnt", done_cnt, 1);
    check("t6_pix", pix_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_draw_scheduler.md
Name: vga_draw_scheduler

Overview:
Queues rectangle-blit commands (image select, origin, size) and sequences them onto the single VGA plot port and the shared image-ROM address bus, one pixel per clock. It replaces ad-hoc plot counters in the VGA control path: game FSMs push "draw background / draw card N at (x,y) / draw game-over" commands, and this block walks each rectangle. It emits ROM addresses, aligns plot coordinates to ROM read latency, clips off-screen pixels and reports completion.

Parameters:
FIFO_DEPTH, 4, command queue entries (power of 2, >=2)
ROM_LATENCY, 1, clocks from rom_address to valid ROM q (1..3)
SCREEN_W, 160, visible columns
SCREEN_H, 120, visible rows

Ports:
clock  in  1  single system clock, rising edge
resetn  in  1  asynchronous, active-low reset
flush  in  1  sync abort: empty queue, cancel current blit
cmd_valid  in  1  command offered
cmd_ready  out  1  queue can accept (= !full && !flush)
cmd_img  in  4  image select code (vga_draw_pkg)
cmd_x  in  8  origin column
cmd_y  in  7  origin row
cmd_w  in  8  width, 0..160
cmd_h  in  7  height, 0..120
rom_address  out  15  address into selected image ROM
img_select  out  4  colour-mux select, aligned with plot outputs
x_plot  out  8  pixel column, aligned with ROM q
y_plot  out  7  pixel row, aligned with ROM q
vga_enable  out  1  write pixel this cycle
busy  out  1  blit in progress or queue non-empty
blit_done  out  1  one-cycle pulse per completed command

Behaviour:
- Reset (async, resetn=0): queue empty, state IDLE, all outputs 0 except cmd_ready=1. A partial blit is abandoned with no blit_done.
- Push on clock edge when cmd_valid && cmd_ready. A push and a pop in the same cycle are legal; when full, that combination leaves count unchanged.
- FSM states:
  - IDLE: if queue non-empty, pop into working registers and go to LOAD.
  - LOAD (1 cycle): clear col/row/addr counters and go to DRAW. If w==0 or h==0, go to DRAIN directly with no pixels issued.
  - DRAW: one rom_address per cycle, addr = row*w + col, produced by an incrementing 15-bit counter (no multiplier). col runs 0..w-1, then resets to 0 and row increments. After the pixel at col=w-1, row=h-1, go to DRAIN.
  - DRAIN: wait ROM_LATENCY cycles for the last pixel, then pulse blit_done for 1 cycle and return to IDLE. A non-empty queue pops on that same IDLE cycle, so blits are back-to-back with a 2-cycle gap.
- Plot pipeline: {x0+col, y0+row, in_bounds, img} is delayed ROM_LATENCY stages.
  - vga_enable = delayed (DRAW && in_bounds).
  - in_bounds = (x0+col < SCREEN_W) && (y0+row < SCREEN_H), computed at 9/8-bit width so there is no wrap.
  - Clipped pixels still advance the address but are never plotted.
- Latency: command accepted at edge E0 into an empty, idle block. Pop at E1, LOAD after E1, first rom_address after E2, first vga_enable ROM_LATENCY cycles after that.
- flush: at the next edge the queue empties, state goes to IDLE, the pipeline valid bits clear (vga_enable=0 from that cycle on), and no blit_done is issued. flush beats a simultaneous push; the push is dropped because cmd_ready=0.
- busy = (state!=IDLE) || !empty || any pipeline stage valid.
- Command fields are sampled only at push. Later input changes do not affect queued or active blits.

Decomposition:
- Package vga_draw_pkg holds:
  - SCREEN_W/SCREEN_H
  - image codes IMG_START=0, IMG_CARD1..IMG_CARD7=1..7, IMG_BACKGROUND=8, IMG_GAMEOVER=9
  - state encoding IDLE/LOAD/DRAW/DRAIN
  - the draw-command record (img, x, y, w, h = 34 bits)
- One sub-module, draw_cmd_fifo: synchronous FIFO, async active-low reset, flush, full/empty/count.

Test Plan:
1. Push {img=8,x=0,y=0,w=160,h=120} -> exactly 19200 vga_enable cycles. First pixel (0,0) with addr 0, last (159,119) with addr 19199. One blit_done, ROM_LATENCY+1 cycles after the last address.
2. Card {img=3,x=150,y=40,w=20,h=40} -> rom_address 0..799 in order. 400 vga_enable cycles, all with x_plot 150..159. Row 40 column 159 carries addr 9, and img_select=3 throughout.
3. During a full-screen blit push 5 commands -> first 4 accepted, cmd_ready low with 5th held. 5th accepted only after the next pop; all 5 later complete in push order with 5 blit_done pulses.
4. Command with w=0 -> no vga_enable, blit_done exactly once. The following queued command starts normally.
5. flush asserted at pixel 500 of a background blit with 2 queued -> vga_enable 0 from the next cycle. No blit_done, busy=0, cmd_ready=1 afterward.
6. resetn pulsed low mid-blit (asynchronously, between edges) -> outputs 0 immediately. After release, a fresh command draws from addr 0.
